scp_light_sequencer: RTL and testbench
======================================

// Module: scp_light_sequencer
// PURPOSE
//  Sequences the green/yellow/red light inputs and the 6-bit phase timer consumed by the scp_079 FSM.
//  Cycles IDLE -> GREEN -> YELLOW -> RED -> GREEN with programmable phase lengths.
//  An alarm requester can preempt into RED through a req/ack handshake.
//  Sits between the top-level clock/control and the scp_079 instance.
// PARAMETERS
//  TW         6   timer width in bits (matches the scp_079 timer port)
//  GREEN_LEN  40  GREEN phase length in clocks, 1..2**TW; default reaches the 35 threshold
//  YELLOW_LEN 10  YELLOW phase length in clocks, 1..2**TW
//  RED_LEN    30  RED phase length in clocks, 1..2**TW; default reaches the 25 threshold
// PORTS
//  clock      in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  enable     in   1   run sequencer; 0 forces IDLE
//  alarm_req  in   1   alarm request; accepted on its rising edge
//  alarm_ack  out  1   one-cycle pulse, accepted alarm
//  green      out  1   light to scp_079, high in GREEN
//  yellow     out  1   light to scp_079, high in YELLOW
//  red        out  1   light to scp_079, high in RED
//  timer      out  TW  clocks elapsed in current phase, 0..LEN-1
//  phase      out  2   00 IDLE, 01 GREEN, 10 YELLOW, 11 RED
//  cycle_done out  1   one-cycle pulse on the RED->GREEN transition
//  hold       in   1   freeze input; present only with SCP_LIGHT_HOLD_EN
// BEHAVIOUR
//  - Reset (async, reset_n=0): phase=IDLE; timer=0; every output 0; internal alarm_req_d=0.
//  - All outputs are registered. Lights are a one-hot decode of the phase register; all are 0 in IDLE.
//  - IDLE: enable=1 -> GREEN next clock with timer=0; otherwise stay in IDLE.
//  - Active phase: timer+1 each clock. At timer==LEN-1, advance GREEN->YELLOW->RED->GREEN next clock, timer=0.
//  - timer never exceeds LEN-1 and never wraps. LEN=1 gives a 1-clock phase with timer stuck at 0.
//  - cycle_done=1 in the same clock in which phase becomes GREEN from RED. It is not asserted on IDLE->GREEN.
//  - Alarm accept = alarm_req & ~alarm_req_d, evaluated only in an active phase.
//  - Accepted alarm in GREEN/YELLOW: RED next clock, timer=0, alarm_ack=1 in that same clock.
//  - Accepted alarm in RED: stay in RED, timer restarts at 0, alarm_ack=1.
//  - alarm_req held high produces no further acks. A rising edge while in IDLE or while enable=0 is ignored with no ack.
//  - Priority, highest first: reset_n=0, then enable=0 (IDLE next clock, timer=0, no ack), then alarm accept, then phase timeout.
//  - An alarm that coincides with a RED timeout keeps RED with timer=0 and does not pulse cycle_done.
//  - Deasserting enable mid-phase, then re-enabling, always restarts from GREEN with timer=0.
// CONFIGURATION
//  - SCP_LIGHT_HOLD_EN defined: hold port exists. hold=1 in an active phase freezes phase and timer.
//    During hold, lights keep their values, no timeout occurs, and alarm accept is still honoured.
//    enable=0 still overrides hold.
//  - SCP_LIGHT_HOLD_EN undefined: no hold port; timer always advances in active phases.
// STRUCTURE
//  - Package scp_pkg: phase encodings (PH_IDLE, PH_GREEN, PH_YELLOW, PH_RED) and the default TW=6.
//    scp_079 also uses these constants.
//  - Sub-module scp_phase_timer: TW-bit counter with clear, hold, and terminal-count compare against a length input.
//  - Top level: phase FSM, alarm edge detect, light decode, and the cycle_done/alarm_ack pulse registers.
// TESTING
//  1. Reset, then enable=1 with defaults: GREEN for 40 clocks (timer 0..39), YELLOW for 10, RED for 30.
//     Then GREEN again with cycle_done=1 for one clock.
//  2. Alarm rising edge at GREEN timer=12: next clock red=1, timer=0, alarm_ack=1 for 1 clock.
//     alarm_req held high for 50 clocks gives no second ack.
//  3. Alarm rising edge at RED timer=20: stay RED, timer back to 0, ack=1.
//     RED then lasts 30 further clocks before returning to GREEN.
//  4. enable=0 at YELLOW timer=5: next clock phase=00, all lights 0, timer=0.
//     Re-enable gives GREEN with timer=0 and cycle_done=0.
//  5. reset_n asserted mid-RED, asynchronously between clock edges: all outputs 0 immediately.
//     With enable held at 1, GREEN starts on the first clock after release.
//  6. With SCP_LIGHT_HOLD_EN: hold=1 for 8 clocks at GREEN timer=30 freezes timer at 30 with green=1.
//     An alarm edge during the hold still gives RED and ack.

Source files
------------

// File: rtl/scp_pkg.sv
// Shared phase encodings and default timer width for the light sequencer and scp_079.
package scp_pkg;

    localparam int TW_DEFAULT = 6;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_RED    = 2'b11
    } phase_e;

endpackage

// File: rtl/scp_phase_timer.sv
// Phase timer: TW-bit up-counter with clear and hold, plus a terminal-count flag at len-1.
module scp_phase_timer #(
    parameter int TW = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          hold,
    input  logic [TW:0]   len,
    output logic [TW-1:0] count,
    output logic          tc
);

    // len spans 1..2**TW, so the compare is done one bit wider than the count
    assign tc = ({1'b0, count} == (len - (TW+1)'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/scp_light_sequencer.sv
// GREEN/YELLOW/RED phase sequencer with alarm preemption into RED.
// Optional freeze input built when SCP_LIGHT_HOLD_EN is defined.
module scp_light_sequencer
    import scp_pkg::*;
#(
    parameter int TW         = TW_DEFAULT,
    parameter int GREEN_LEN  = 40,
    parameter int YELLOW_LEN = 10,
    parameter int RED_LEN    = 30
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          alarm_req,
    output logic          alarm_ack,
    output logic          green,
    output logic          yellow,
    output logic          red,
    output logic [TW-1:0] timer,
    output logic [1:0]    phase,
    output logic          cycle_done
`ifdef SCP_LIGHT_HOLD_EN
    ,
    input  logic          hold
`endif
);

    phase_e      phase_q, phase_nx;
    logic        alarm_req_d;
    logic        alarm_edge;
    logic        freeze;
    logic        cnt_clear, cnt_hold, cnt_tc;
    logic        ack_nx, done_nx;
    logic [TW:0] len_sel;

`ifdef SCP_LIGHT_HOLD_EN
    assign freeze = hold;
`else
    assign freeze = 1'b0;
`endif

    assign alarm_edge = alarm_req & ~alarm_req_d;
    assign phase      = phase_q;

    always_comb begin
        len_sel = (TW+1)'(GREEN_LEN);
        case (phase_q)
            PH_YELLOW: len_sel = (TW+1)'(YELLOW_LEN);
            PH_RED:    len_sel = (TW+1)'(RED_LEN);
            default:   len_sel = (TW+1)'(GREEN_LEN);
        endcase
    end

    scp_phase_timer #(.TW(TW)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .hold    (cnt_hold),
        .len     (len_sel),
        .count   (timer),
        .tc      (cnt_tc)
    );

    // enable beats alarm, alarm beats hold and timeout
    always_comb begin
        phase_nx  = phase_q;
        cnt_clear = 1'b0;
        cnt_hold  = 1'b0;
        ack_nx    = 1'b0;
        done_nx   = 1'b0;
        if (!enable) begin
            phase_nx  = PH_IDLE;
            cnt_clear = 1'b1;
        end else if (phase_q == PH_IDLE) begin
            phase_nx  = PH_GREEN;
            cnt_clear = 1'b1;
        end else if (alarm_edge) begin
            phase_nx  = PH_RED;
            cnt_clear = 1'b1;
            ack_nx    = 1'b1;
        end else if (freeze) begin
            cnt_hold  = 1'b1;
        end else if (cnt_tc) begin
            cnt_clear = 1'b1;
            case (phase_q)
                PH_GREEN:  phase_nx = PH_YELLOW;
                PH_YELLOW: phase_nx = PH_RED;
                default: begin
                    phase_nx = PH_GREEN;
                    done_nx  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= PH_IDLE;
            alarm_req_d <= 1'b0;
            alarm_ack   <= 1'b0;
            cycle_done  <= 1'b0;
            green       <= 1'b0;
            yellow      <= 1'b0;
            red         <= 1'b0;
        end else begin
            phase_q     <= phase_nx;
            alarm_req_d <= alarm_req;
            alarm_ack   <= ack_nx;
            cycle_done  <= done_nx;
            green       <= (phase_nx == PH_GREEN);
            yellow      <= (phase_nx == PH_YELLOW);
            red         <= (phase_nx == PH_RED);
        end
    end

endmodule

// File: tb/tb_scp_light_sequencer.sv
// Directed bench for scp_light_sequencer; hold checks built when SCP_LIGHT_HOLD_EN is defined.
module tb_scp_light_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       alarm_req;
    logic       alarm_ack;
    logic       green, yellow, red;
    logic [5:0] timer;
    logic [1:0] phase;
    logic       cycle_done;
`ifdef SCP_LIGHT_HOLD_EN
    logic       hold;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    scp_light_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .alarm_req  (alarm_req),
        .alarm_ack  (alarm_ack),
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .timer      (timer),
        .phase      (phase),
        .cycle_done (cycle_done)
`ifdef SCP_LIGHT_HOLD_EN
        ,
        .hold       (hold)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // lights, phase, timer, cycle_done, ack packed into one word
    function automatic logic [31:0] snap();
        return 32'({green, yellow, red, phase, timer, cycle_done, alarm_ack});
    endfunction

    function automatic logic [31:0] want(input logic [2:0] l, input logic [1:0] p,
                                         input int t, input logic cd, input logic ak);
        return 32'({l, p, 6'(t), cd, ak});
    endfunction

    task automatic wait_state(input string tag, input logic [1:0] p, input int t);
        int n = 0;
        while (!(phase == p && timer == 6'(t)) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(phase == p && timer == 6'(t)), 32'd1);
    endtask

    initial begin
        logic ack_seen;
        reset_n   = 1'b0;
        enable    = 1'b0;
        alarm_req = 1'b0;
`ifdef SCP_LIGHT_HOLD_EN
        hold      = 1'b0;
`endif
        #12;
        check("reset_state", snap(), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("idle_no_enable", snap(), 32'd0);

        // full cycle with default lengths
        enable = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            check("green_run", snap(), want(3'b100, 2'b01, i, 1'b0, 1'b0));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check("yellow_run", snap(), want(3'b010, 2'b10, i, 1'b0, 1'b0));
            tick();
        end
        for (int i = 0; i < 30; i++) begin
            check("red_run", snap(), want(3'b001, 2'b11, i, 1'b0, 1'b0));
            tick();
        end
        check("cycle_done_pulse", snap(), want(3'b100, 2'b01, 0, 1'b1, 1'b0));
        tick();
        check("cycle_done_clear", snap(), want(3'b100, 2'b01, 1, 1'b0, 1'b0));

        // alarm during GREEN, then held high
        wait_state("reach_green_12", 2'b01, 12);
        alarm_req = 1'b1;
        tick();
        check("alarm_green_ack", snap(), want(3'b001, 2'b11, 0, 1'b0, 1'b1));
        ack_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            ack_seen |= alarm_ack;
        end
        check("alarm_held_no_ack", 32'(ack_seen), 32'd0);
        alarm_req = 1'b0;

        // alarm during RED restarts RED
        wait_state("reach_red_20", 2'b11, 20);
        alarm_req = 1'b1;
        tick();
        check("alarm_red_ack", snap(), want(3'b001, 2'b11, 0, 1'b0, 1'b1));
        alarm_req = 1'b0;
        for (int i = 1; i < 30; i++) begin
            tick();
            check("red_restart_run", snap(), want(3'b001, 2'b11, i, 1'b0, 1'b0));
        end
        tick();
        check("red_restart_exit", snap(), want(3'b100, 2'b01, 0, 1'b1, 1'b0));

        // alarm edge while disabled is ignored
        wait_state("reach_yellow_5", 2'b10, 5);
        enable = 1'b0;
        tick();
        check("disable_idle", snap(), 32'd0);
        alarm_req = 1'b1;
        tick();
        check("alarm_idle_ignored", snap(), 32'd0);
        enable = 1'b1;
        tick();
        check("reenable_green", snap(), want(3'b100, 2'b01, 0, 1'b0, 1'b0));
        alarm_req = 1'b0;
        tick();

        // asynchronous reset mid-RED
        wait_state("reach_red_any", 2'b11, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", snap(), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post_reset_green", snap(), want(3'b100, 2'b01, 0, 1'b0, 1'b0));

`ifdef SCP_LIGHT_HOLD_EN
        wait_state("reach_green_30", 2'b01, 30);
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("hold_freeze", snap(), want(3'b100, 2'b01, 30, 1'b0, 1'b0));
        end
        alarm_req = 1'b1;
        tick();
        check("hold_alarm", snap(), want(3'b001, 2'b11, 0, 1'b0, 1'b1));
        hold = 1'b0;
        alarm_req = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
